obstaculos_scroll: RTL and testbench
====================================

# obstaculos_scroll

Obstacle generator and scroller for the three-digit seven-segment playfield. It produces the 21-bit `display_obs` bus that the collision stage compares segment-by-segment against the hero. On each obstacle tick during play, it shifts obstacles one digit toward the hero digit and spawns new pseudo-random patterns at the far digit. It also counts obstacles that pass the hero.

## Interface

Parameters:
- `OFF`, `WLCM`, `CH`, `GAME`, `WL`, `PA`: 3'd0..3'd5; main state-machine encodings for `presente`.
- `SEED`: 8'hA5; LFSR load value, must be nonzero.
- `MIN_GAP`: 1; minimum number of forced-blank ticks after each spawn, range 0..7.

Ports:
- `clk` in 1: system clock. One clock domain; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: single-`clk`-cycle obstacle-rate enable, aligned with the `clk_obstaculos` rate.
- `presente` in 3: current main FSM state.
- `display_obs` out 21: {digit2[20:14], digit1[13:7], digit0[6:0]}. digit0 is the hero digit. Segments are active-high, bit6=a … bit0=g.
- `score` out 8: obstacles passed, saturating.
- `spawned` out 1: one-cycle pulse on the cycle after a tick that loaded a non-blank digit2.

## Operation

Internal regs:
- d0, d1, d2 (7b each)
- lfsr (8b)
- gap (3b)
- score (8b)
- mode (2b)

Mode FSM, re-evaluated every cycle from `presente`:
- **CLEAR**: `presente` ∈ {OFF, WLCM, CH} or undefined (3'd6, 3'd7).
  - d0..d2 = 0, lfsr = SEED, gap = 0, score = 0.
  - `tick` is ignored.
- **RUN**: `presente` == GAME. Each `tick` applies all of the following at once:
  - If d0 != 0 and score != 8'hFF: score += 1.
  - Shift: d0 ← d1, d1 ← d2.
  - Spawn decision uses the pre-advance lfsr:
    - If gap != 0: d2 ← 0, gap ← gap − 1.
    - Else if lfsr[0] == 0: d2 ← PAT(lfsr[2:1]), gap ← MIN_GAP, `spawned` = 1 on the next cycle.
    - Else: d2 ← 0.
  - lfsr advances: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- **HOLD**: `presente` ∈ {WL, PA}.
  - All registers are frozen and `display_obs` is stable, so collision keeps seeing the crash frame.
  - `tick` is ignored.
- Transition behaviour:
  - HOLD→RUN resumes exactly where the frame froze, with no re-clear.
  - Any →CLEAR wipes state on the next edge.
- PAT table:
  - 00 → 7'b1000000 (a, top)
  - 01 → 7'b0000001 (g, middle)
  - 10 → 7'b0001000 (d, bottom)
  - 11 → 7'b1001000 (a+d)
- Every pattern leaves at least one row free, so every obstacle is avoidable.

## Timing

- Reset values (`rst` high at an edge):
  - `display_obs` = 21'h0, `score` = 0, `spawned` = 0.
  - lfsr = SEED, gap = 0.
- Reset priority:
  - `rst` overrides `tick` and `presente`.
  - A reset arriving mid-game clears state on that edge.
- Latency:
  - `display_obs` and `score` update on the `clk` edge where `tick` = 1 and `presente` == GAME. They are visible the following cycle.
  - `spawned` is high for exactly that one following cycle.
- Simultaneous events:
  - If `presente` leaves GAME in the same cycle as `tick`, the new mode wins and no shift occurs.
  - If `presente` enters GAME in the same cycle as `tick`, the tick is processed as RUN.
- Outputs only change on `tick` edges, so `display_obs` is stable across the collision stage's negedge sample.
- Score saturation: at 8'hFF, score holds while shifting continues.
- With `MIN_GAP` = 0, spawns may occur back-to-back on consecutive ticks.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan

1. **Reset.** Hold `rst` for 2 cycles with `presente` = GAME and `tick` = 1.
   - `display_obs` = 0, `score` = 0, `spawned` = 0.
   - First post-reset tick runs with lfsr = 8'hA5.
2. **Deterministic sequence.** `presente` = GAME, `MIN_GAP` = 1, issue 5 ticks.
   - LFSR values across the ticks: A5, 4A, 95, 2A, 54.
   - After tick2: `display_obs` = 21'h004000, `spawned` pulses.
   - After tick3: 21'h000080.
   - After tick4: 21'h004001.
   - After tick5: d0 = 0, forced gap, `score` = 1.
3. **Freeze.** Mid-game, set `presente` = WL and pulse `tick` 10 times.
   - `display_obs` and `score` remain unchanged.
   - Return to GAME: the next tick shifts from the frozen frame.
4. **Clear.** From a non-empty frame, set `presente` = WLCM for 1 cycle, then GAME.
   - All zero; the next tick sequence repeats scenario 2 exactly.
5. **Tick/mode collision.** `tick` and `presente` GAME→PA in the same cycle.
   - No shift, lfsr unchanged.
6. **Saturation.** Run until `score` reaches 8'hFF with obstacles still passing.
   - `score` stays 8'hFF; `display_obs` keeps scrolling.

Source files
------------

// File: rtl/obstaculos_scroll.sv
// Obstacle spawner/scroller for the three-digit seven-segment playfield.
// Shifts obstacles toward the hero digit on each tick and counts the ones that pass.
module obstaculos_scroll #(
    parameter logic [2:0]  OFF     = 3'd0,
    parameter logic [2:0]  WLCM    = 3'd1,
    parameter logic [2:0]  CH      = 3'd2,
    parameter logic [2:0]  GAME    = 3'd3,
    parameter logic [2:0]  WL      = 3'd4,
    parameter logic [2:0]  PA      = 3'd5,
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int unsigned MIN_GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  presente,
    output logic [20:0] display_obs,
    output logic [7:0]  score,
    output logic        spawned
);

    typedef enum logic [1:0] {
        M_CLEAR = 2'd0,
        M_RUN   = 2'd1,
        M_HOLD  = 2'd2
    } mode_e;

    localparam logic [2:0] GAP_LD = 3'(MIN_GAP);

    mode_e      mode;
    logic [6:0] d0_q, d0_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] d2_q, d2_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] gap_q, gap_d;
    logic [7:0] score_q, score_d;
    logic       spawned_q, spawned_d;

    function automatic logic [6:0] pat(input logic [1:0] sel);
        case (sel)
            2'b00:   pat = 7'b1000000;
            2'b01:   pat = 7'b0000001;
            2'b10:   pat = 7'b0001000;
            default: pat = 7'b1001000;
        endcase
    endfunction

    // Mode is decoded from the current state so a tick in the entry cycle counts.
    always_comb begin
        mode = M_CLEAR;
        if (presente == GAME) begin
            mode = M_RUN;
        end else if (presente == WL || presente == PA) begin
            mode = M_HOLD;
        end
    end

    always_comb begin
        d0_d      = d0_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        lfsr_d    = lfsr_q;
        gap_d     = gap_q;
        score_d   = score_q;
        spawned_d = 1'b0;
        case (mode)
            M_CLEAR: begin
                d0_d    = '0;
                d1_d    = '0;
                d2_d    = '0;
                lfsr_d  = SEED;
                gap_d   = '0;
                score_d = '0;
            end
            M_RUN: begin
                if (tick) begin
                    if (d0_q != '0 && score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    d0_d = d1_q;
                    d1_d = d2_q;
                    if (gap_q != '0) begin
                        d2_d  = '0;
                        gap_d = gap_q - 3'd1;
                    end else if (!lfsr_q[0]) begin
                        d2_d      = pat(lfsr_q[2:1]);
                        gap_d     = GAP_LD;
                        spawned_d = 1'b1;
                    end else begin
                        d2_d = '0;
                    end
                    lfsr_d = {lfsr_q[6:0],
                              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            lfsr_q    <= SEED;
            gap_q     <= '0;
            score_q   <= '0;
            spawned_q <= 1'b0;
        end else begin
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            lfsr_q    <= lfsr_d;
            gap_q     <= gap_d;
            score_q   <= score_d;
            spawned_q <= spawned_d;
        end
    end

    assign display_obs = {d2_q, d1_q, d0_q};
    assign score       = score_q;
    assign spawned     = spawned_q;

endmodule

// File: tb/tb_obstaculos_scroll.sv
// Randomized bench for obstaculos_scroll against a lane-array reference model.
// Directed scenarios check fixed frames; all cycles are also model-checked.
module tb_obstaculos_scroll;

    localparam logic [2:0] OFF  = 3'd0;
    localparam logic [2:0] WLCM = 3'd1;
    localparam logic [2:0] GAME = 3'd3;
    localparam logic [2:0] WL   = 3'd4;
    localparam logic [2:0] PA   = 3'd5;
    localparam int         GAPN = 1;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [2:0]  presente;
    logic [20:0] display_obs;
    logic [7:0]  score;
    logic        spawned;

    int n_chk;
    int n_fail;

    int m_lane [3];
    int m_lfsr;
    int m_gap;
    int m_score;
    int m_sp;
    int pats [4] = '{64, 1, 8, 72};

    obstaculos_scroll dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .presente(presente),
        .display_obs(display_obs),
        .score(score),
        .spawned(spawned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic t, input logic [2:0] p);
        int nxt;
        int fb;
        m_sp = 0;
        if (r || !(p == GAME || p == WL || p == PA)) begin
            m_lane = '{0, 0, 0};
            m_lfsr = 165;
            m_gap = 0;
            m_score = 0;
        end else if (p == GAME && t) begin
            if (m_lane[0] != 0 && m_score < 255) m_score++;
            if (m_gap > 0) begin
                nxt = 0;
                m_gap--;
            end else if (m_lfsr % 2 == 0) begin
                nxt = pats[(m_lfsr / 2) % 4];
                m_gap = GAPN;
                m_sp = 1;
            end else begin
                nxt = 0;
            end
            m_lane[0] = m_lane[1];
            m_lane[1] = m_lane[2];
            m_lane[2] = nxt;
            fb = 0;
            for (int b = 0; b < 8; b++)
                if ((8'hB8 >> b) & 1) fb ^= (m_lfsr >> b) & 1;
            m_lfsr = ((m_lfsr * 2) % 256) + fb;
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [2:0] p);
        rst = r;
        tick = t;
        presente = p;
        @(posedge clk);
        model(r, t, p);
        #1;
        check("disp", 32'(display_obs),
              32'((m_lane[2] << 14) | (m_lane[1] << 7) | m_lane[0]));
        check("score", 32'(score), 32'(m_score));
        check("spawned", 32'(spawned), 32'(m_sp));
    endtask

    task automatic scen2();
        step(0, 1, GAME);
        check("s2_t1", 32'(display_obs), 32'h0);
        step(0, 1, GAME);
        check("s2_t2", 32'(display_obs), 32'h004000);
        check("s2_sp2", 32'(spawned), 32'h1);
        step(0, 1, GAME);
        check("s2_t3", 32'(display_obs), 32'h000080);
        check("s2_sp3", 32'(spawned), 32'h0);
        step(0, 1, GAME);
        check("s2_t4", 32'(display_obs), 32'h004001);
        step(0, 1, GAME);
        check("s2_t5", 32'(display_obs), 32'h000080);
        check("s2_sc5", 32'(score), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [20:0] saved_d;
    logic [7:0]  saved_s;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        tick = 1'b1;
        presente = GAME;
        step(1, 1, GAME);
        step(1, 1, GAME);
        check("rst_disp", 32'(display_obs), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_sp", 32'(spawned), 32'h0);

        scen2();

        for (int i = 0; i < 3; i++) step(0, 1, GAME);
        saved_d = display_obs;
        saved_s = score;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, WL);
            step(0, 0, WL);
        end
        check("frz_disp", 32'(display_obs), 32'(saved_d));
        check("frz_score", 32'(score), 32'(saved_s));
        step(0, 1, GAME);
        check("frz_resume", 32'(display_obs[13:0]), 32'(saved_d[20:7]));

        step(0, 0, WLCM);
        check("clr_disp", 32'(display_obs), 32'h0);
        check("clr_score", 32'(score), 32'h0);
        scen2();

        for (int i = 0; i < 4; i++) step(0, 1, GAME);
        saved_d = display_obs;
        step(0, 1, PA);
        check("col_disp", 32'(display_obs), 32'(saved_d));
        step(0, 0, GAME);
        for (int i = 0; i < 6; i++) step(0, 1, GAME);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] p;
            p = ($urandom_range(0, 9) < 7) ? GAME : 3'($urandom_range(0, 7));
            step($urandom_range(0, 99) == 0, 1'($urandom), p);
        end

        step(0, 0, OFF);
        for (int i = 0; i < 2000; i++) step(0, 1, GAME);
        check("sat", 32'(score), 32'hFF);
        saved_d = display_obs;
        for (int i = 0; i < 30; i++) step(0, 1, GAME);
        check("sat_hold", 32'(score), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
